// File: rtl/hour_editor.sv
// ============================================================================
// Module   : hour_editor
// Purpose  : Writer side of the clock display. Passes live RTC time to the
//            renderer when idle. In program mode it edits a snapshot of the
//            time with the buttons and commits it to the RTC over req/ack.
//            Optional hold-to-repeat on up/down: HOUR_EDITOR_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hour_editor #(
  parameter logic [7:0] HOUR_MAX      = 8'h23,
  parameter logic [7:0] MINSEC_MAX    = 8'h59,
  parameter int         HOLD_CYCLES   = 50000000,
  parameter int         REPEAT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_req,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_ok,
  input  logic [7:0]  rtc_hour_in1,
  input  logic [7:0]  rtc_hour_in2,
  input  logic [7:0]  rtc_hour_in3,
  input  logic        wr_ack,
  output logic [7:0]  hour_out1,
  output logic [7:0]  hour_out2,
  output logic [7:0]  hour_out3,
  output logic        programar_on,
  output logic [3:0]  direccion_actual_pantalla,
  output logic        wr_req,
  output logic [23:0] wr_data
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_EDIT   = 2'd1;
  localparam logic [1:0] c_COMMIT = 2'd2;

  localparam int c_B_OK    = 5;
  localparam int c_B_PROG  = 4;
  localparam int c_B_UP    = 3;
  localparam int c_B_DOWN  = 2;
  localparam int c_B_LEFT  = 1;
  localparam int c_B_RIGHT = 0;

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("hour_editor: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [5:0]  w_btn;
  logic [5:0]  r_sync1;
  logic [5:0]  r_sync2;
  logic [5:0]  r_sync3;
  logic [5:0]  w_pulse;
  logic        w_rep_up;
  logic        w_rep_down;
  logic        w_do_up;
  logic        w_do_down;
  logic        w_do_left;
  logic        w_do_right;
  logic        w_do_ok;
  logic [7:0]  r_hour1;
  logic [7:0]  r_hour2;
  logic [7:0]  r_hour3;
  logic [1:0]  r_cursor;
  logic [23:0] r_wr_data;
  logic [7:0]  w_sel_val;
  logic [7:0]  w_sel_max;
  logic [7:0]  w_sel_new;

  function automatic logic bcd_bad(input logic [7:0] v, input logic [7:0] lim);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v > lim);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (bcd_bad(v, lim) || v == lim) return 8'h00;
    else if (v[3:0] == 4'd9)         return {v[7:4] + 4'd1, 4'h0};
    else                             return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    if (bcd_bad(v, lim))       return 8'h00;
    else if (v == 8'h00)       return lim;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'h9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Two flops of synchronization, the third only feeds the rising-edge detect
  assign w_btn   = {btn_ok, prog_req, btn_up, btn_down, btn_left, btn_right};
  assign w_pulse = r_sync2 & ~r_sync3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; ok outranks prog_req, so cancel only wins when ok is absent
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_pulse[c_B_PROG]) w_state_nxt = c_EDIT;
      c_EDIT: begin
        if (w_pulse[c_B_OK])        w_state_nxt = c_COMMIT;
        else if (w_pulse[c_B_PROG]) w_state_nxt = c_IDLE;
      end
      c_COMMIT: if (wr_ack) w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    programar_on = (r_state != c_IDLE);
    wr_req       = (r_state == c_COMMIT);
  end

`ifdef HOUR_EDITOR_AUTOREPEAT_EN
  logic [1:0] w_hold_lvl;
  logic [1:0] w_rep_step;
  logic       w_hold_clr;

  assign w_hold_lvl = {r_sync2[c_B_UP], r_sync2[c_B_DOWN]};
  assign w_hold_clr = (r_state != c_EDIT) || (w_state_nxt != c_EDIT);

  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    logic [31:0] r_cnt;
    logic        r_rep;
    logic        w_hit;

    assign w_hit = (r_cnt == (r_rep ? 32'(REPEAT_CYCLES - 1) : 32'(HOLD_CYCLES - 1)));
    assign w_rep_step[gi] = w_hold_lvl[gi] && !w_hold_clr && w_hit;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_hold_clr || !w_hold_lvl[gi]) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_hit) begin
        r_cnt <= '0;
        r_rep <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign w_rep_up   = w_rep_step[1];
  assign w_rep_down = w_rep_step[0];
`else
  assign w_rep_up   = 1'b0;
  assign w_rep_down = 1'b0;
`endif

  // Only the highest-priority edit action of a cycle is taken
  always_comb begin
    w_do_ok    = 1'b0;
    w_do_up    = 1'b0;
    w_do_down  = 1'b0;
    w_do_left  = 1'b0;
    w_do_right = 1'b0;
    if (w_pulse[c_B_OK])                    w_do_ok    = 1'b1;
    else if (w_pulse[c_B_PROG])             ;
    else if (w_pulse[c_B_UP] || w_rep_up)   w_do_up    = 1'b1;
    else if (w_pulse[c_B_DOWN] || w_rep_down) w_do_down = 1'b1;
    else if (w_pulse[c_B_LEFT])             w_do_left  = 1'b1;
    else if (w_pulse[c_B_RIGHT])            w_do_right = 1'b1;
  end

  always_comb begin
    w_sel_val = r_hour1;
    w_sel_max = HOUR_MAX;
    case (r_cursor)
      2'd1: begin w_sel_val = r_hour2; w_sel_max = MINSEC_MAX; end
      2'd2: begin w_sel_val = r_hour3; w_sel_max = MINSEC_MAX; end
      default: ;
    endcase
    w_sel_new = w_do_up ? bcd_inc(w_sel_val, w_sel_max) : bcd_dec(w_sel_val, w_sel_max);
  end

  // The display registers double as edit registers: loading them every idle
  // cycle makes the entry snapshot implicit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hour1   <= 8'h00;
      r_hour2   <= 8'h00;
      r_hour3   <= 8'h00;
      r_cursor  <= 2'd0;
      r_wr_data <= 24'h0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_hour1 <= rtc_hour_in1;
          r_hour2 <= rtc_hour_in2;
          r_hour3 <= rtc_hour_in3;
          if (w_pulse[c_B_PROG]) r_cursor <= 2'd0;
        end
        c_EDIT: begin
          if (w_do_up || w_do_down) begin
            case (r_cursor)
              2'd0:    r_hour1 <= w_sel_new;
              2'd1:    r_hour2 <= w_sel_new;
              2'd2:    r_hour3 <= w_sel_new;
              default: ;
            endcase
          end
          if (w_do_left)  r_cursor <= (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
          if (w_do_right) r_cursor <= (r_cursor >= 2'd2) ? 2'd0 : r_cursor + 2'd1;
          if (w_do_ok)    r_wr_data <= {r_hour1, r_hour2, r_hour3};
        end
        default: ;
      endcase
    end
  end

  assign hour_out1                 = r_hour1;
  assign hour_out2                 = r_hour2;
  assign hour_out3                 = r_hour3;
  assign direccion_actual_pantalla = {2'b00, r_cursor};
  assign wr_data                   = r_wr_data;

endmodule

`default_nettype wire
